// File: rtl/fetch_stage.sv
// brisc instruction fetch: PC register, single-outstanding imem handshake,
// direct-mapped BTB with 2-bit counters, NOP bubble when nothing is deliverable.

module fetch_btb_entry #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel,
  input  logic             taken,
  input  logic [TAG_W-1:0] upd_tag,
  input  logic [XLEN-1:0]  upd_target,
  output logic             valid,
  output logic [TAG_W-1:0] tag,
  output logic [XLEN-1:0]  target,
  output logic             pred_bit
);
  logic [1:0] ctr;
  logic       hit;

  assign hit      = valid && (tag == upd_tag);
  assign pred_bit = ctr[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid  <= 1'b0;
      tag    <= '0;
      target <= '0;
      ctr    <= 2'b01;
    end else if (sel) begin
      if (taken) begin
        target <= upd_target;
        if (hit) begin
          if (ctr != 2'b11) ctr <= ctr + 2'd1;
        end else begin
          valid <= 1'b1;
          tag   <= upd_tag;
          ctr   <= 2'b10;
        end
      end else if (hit && ctr != 2'b00) begin
        ctr <= ctr - 2'd1;
      end
    end
  end
endmodule

module fetch_stage #(
  parameter int              XLEN        = 32,
  parameter int              ILEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [ILEN-1:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_in,
  input  logic            redirect_in,
  input  logic [XLEN-1:0] redirect_pc_in,
  input  logic            btb_update_in,
  input  logic [XLEN-1:0] btb_update_pc_in,
  input  logic [XLEN-1:0] btb_update_target_in,
  input  logic            btb_update_taken_in,
  output logic            imem_req_out,
  output logic [XLEN-1:0] imem_addr_out,
  input  logic            imem_ready_in,
  input  logic            imem_valid_in,
  input  logic [ILEN-1:0] imem_data_in,
  output logic [ILEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4_out,
  output logic            pred_taken_out
);
  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;

  typedef enum logic [1:0] {REQ, WAIT, HOLD, DISCARD} state_t;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            pred;
  } fd_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc_q, infl_pc_q, hold_pc_q;
  logic            infl_pred_q, hold_pred_q;
  logic [ILEN-1:0] hold_instr_q;

  logic resp, req, accept, capture, pred;
  fd_t  dlv;
  logic dlv_valid;

  // ---------------- BTB ----------------
  logic [BTB_ENTRIES-1:0]            e_valid, e_pred;
  logic [BTB_ENTRIES-1:0][TAG_W-1:0] e_tag;
  logic [BTB_ENTRIES-1:0][XLEN-1:0]  e_target;
  logic [IDX-1:0]                    lk_idx, up_idx;
  logic [TAG_W-1:0]                  lk_tag, up_tag;
  logic [XLEN-1:0]                   btb_target;
  logic                              unused_bits;

  assign lk_idx      = pc_q[IDX+1:2];
  assign lk_tag      = pc_q[XLEN-1:IDX+2];
  assign up_idx      = btb_update_pc_in[IDX+1:2];
  assign up_tag      = btb_update_pc_in[XLEN-1:IDX+2];
  assign unused_bits = ^btb_update_pc_in[1:0];

  for (genvar g = 0; g < BTB_ENTRIES; g++) begin : g_btb
    fetch_btb_entry #(.XLEN(XLEN), .TAG_W(TAG_W)) u_entry (
      .clk        (clk),
      .reset      (reset),
      .sel        (btb_update_in && (up_idx == IDX'(g))),
      .taken      (btb_update_taken_in),
      .upd_tag    (up_tag),
      .upd_target (btb_update_target_in),
      .valid      (e_valid[g]),
      .tag        (e_tag[g]),
      .target     (e_target[g]),
      .pred_bit   (e_pred[g])
    );
  end

  // Lookup reads registered entries, so a same-cycle update is seen one cycle later.
  assign pred       = e_valid[lk_idx] && (e_tag[lk_idx] == lk_tag) && e_pred[lk_idx];
  assign btb_target = e_target[lk_idx];

  // ---------------- handshake ----------------
  assign resp    = (state == WAIT) && imem_valid_in;
  assign req     = !redirect_in && ((state == REQ) || (resp && !stall_in) ||
                                    ((state == HOLD) && !stall_in));
  assign accept  = req && imem_ready_in;
  assign capture = resp && stall_in && !redirect_in;

  assign imem_req_out  = req;
  assign imem_addr_out = pc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= REQ;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (redirect_in) begin
      case (state)
        WAIT, DISCARD: state_nxt = imem_valid_in ? REQ : DISCARD;
        default:       state_nxt = REQ;
      endcase
    end else begin
      case (state)
        REQ:     state_nxt = accept ? WAIT : REQ;
        WAIT:    if (imem_valid_in) state_nxt = stall_in ? HOLD : (accept ? WAIT : REQ);
        HOLD:    if (!stall_in) state_nxt = accept ? WAIT : REQ;
        DISCARD: if (imem_valid_in) state_nxt = REQ;
        default: state_nxt = REQ;
      endcase
    end
  end

  always_comb begin
    dlv       = '{instr: NOP_INSTR, pc: '0, pred: 1'b0};
    dlv_valid = 1'b0;
    if (!redirect_in) begin
      if (resp) begin
        dlv       = '{instr: imem_data_in, pc: infl_pc_q, pred: infl_pred_q};
        dlv_valid = 1'b1;
      end else if (state == HOLD) begin
        dlv       = '{instr: hold_instr_q, pc: hold_pc_q, pred: hold_pred_q};
        dlv_valid = 1'b1;
      end
    end
  end

  assign instr_out      = dlv.instr;
  assign pc_out         = dlv.pc;
  assign pred_taken_out = dlv.pred;
  assign pc_plus4_out   = dlv_valid ? dlv.pc + XLEN'(4) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q         <= RESET_PC;
      infl_pc_q    <= '0;
      infl_pred_q  <= 1'b0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      hold_pred_q  <= 1'b0;
    end else begin
      if (redirect_in)  pc_q <= redirect_pc_in;
      else if (accept)  pc_q <= pred ? btb_target : pc_q + XLEN'(4);
      if (accept) begin
        infl_pc_q   <= pc_q;
        infl_pred_q <= pred;
      end
      if (capture) begin
        hold_instr_q <= imem_data_in;
        hold_pc_q    <= infl_pc_q;
        hold_pred_q  <= infl_pred_q;
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: per-cycle vector table, directed BTB/reset sequences,
// then random traffic checked against a fetch-stream reference model.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic F = 1'b0, T = 1'b1;

  logic        clk = 1'b0, reset = 1'b0;
  logic        stall_in = 1'b0, redirect_in = 1'b0, btb_update_in = 1'b0, btb_update_taken_in = 1'b0;
  logic        imem_ready_in = 1'b0, imem_valid_in = 1'b0;
  logic [31:0] redirect_pc_in = '0, btb_update_pc_in = '0, btb_update_target_in = '0, imem_data_in = '0;
  logic        imem_req_out, pred_taken_out;
  logic [31:0] imem_addr_out, instr_out, pc_out, pc_plus4_out;

  int n_pass = 0, n_total = 0;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall_in(stall_in), .redirect_in(redirect_in),
    .redirect_pc_in(redirect_pc_in), .btb_update_in(btb_update_in),
    .btb_update_pc_in(btb_update_pc_in), .btb_update_target_in(btb_update_target_in),
    .btb_update_taken_in(btb_update_taken_in), .imem_req_out(imem_req_out),
    .imem_addr_out(imem_addr_out), .imem_ready_in(imem_ready_in), .imem_valid_in(imem_valid_in),
    .imem_data_in(imem_data_in), .instr_out(instr_out), .pc_out(pc_out),
    .pc_plus4_out(pc_plus4_out), .pred_taken_out(pred_taken_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic st, rd; logic [31:0] rpc; logic rdy, vld; logic [31:0] dpc;
    logic e_req; logic [31:0] e_addr; logic e_dv; logic [31:0] e_pc;
  } vec_t;

  typedef struct { logic [31:0] pc; logic pred; } item_t;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 | (a & 32'h0000_FFFF);
  endfunction

  function automatic vec_t mk(input int st, input int rd, input int rpc, input int rdy, input int vld,
                              input int dpc, input int er, input int ea, input int edv, input int epc);
    vec_t v;
    v.st = st[0]; v.rd = rd[0]; v.rpc = rpc; v.rdy = rdy[0]; v.vld = vld[0]; v.dpc = dpc;
    v.e_req = er[0]; v.e_addr = ea; v.e_dv = edv[0]; v.e_pc = epc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  task automatic chk_out(input string nm, input logic dv, input logic [31:0] pc, input logic pred);
    chk({nm, ".instr"}, instr_out, dv ? mem_word(pc) : NOP);
    chk({nm, ".pc"}, pc_out, dv ? pc : 32'h0);
    chk({nm, ".plus4"}, pc_plus4_out, dv ? pc + 32'h4 : 32'h0);
    chk({nm, ".pred"}, 32'(pred_taken_out), 32'(dv & pred));
  endtask

  task automatic step(input logic st, input logic rd, input logic [31:0] rpc, input logic rdy,
                      input logic vld, input logic [31:0] dpc, input logic u = 1'b0,
                      input logic [31:0] upc = 32'h0, input logic [31:0] utgt = 32'h0,
                      input logic utk = 1'b0);
    @(posedge clk); #1;
    stall_in = st; redirect_in = rd; redirect_pc_in = rpc; imem_ready_in = rdy;
    imem_valid_in = vld; imem_data_in = vld ? mem_word(dpc) : 32'h0;
    btb_update_in = u; btb_update_pc_in = upc; btb_update_target_in = utgt; btb_update_taken_in = utk;
    @(negedge clk);
  endtask

  task automatic do_reset;
    stall_in = F; redirect_in = F; redirect_pc_in = '0; imem_ready_in = F; imem_valid_in = F;
    imem_data_in = '0; btb_update_in = F; btb_update_pc_in = '0; btb_update_target_in = '0;
    btb_update_taken_in = F;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  vec_t        tbl[17];
  item_t       q[$];
  item_t       it;
  logic        mv[16];
  logic [31:0] mpc[16], mtgt[16];
  int          mctr[16];

  initial begin
    logic [31:0] exp_pc, maddr;
    logic [3:0]  bi;
    logic        held, pend, hit, pr;
    int          cnt;

    // st rd rpc rdy vld dpc | req addr dv pc
    tbl[0]  = mk(0,0,0,    1,0,0,     1,'h0,  0,0);
    tbl[1]  = mk(0,0,0,    1,1,0,     1,'h4,  1,'h0);
    tbl[2]  = mk(1,0,0,    1,1,'h4,   0,'h8,  1,'h4);
    tbl[3]  = mk(1,0,0,    1,0,0,     0,'h8,  1,'h4);
    tbl[4]  = mk(1,0,0,    1,0,0,     0,'h8,  1,'h4);
    tbl[5]  = mk(0,0,0,    1,0,0,     1,'h8,  1,'h4);
    tbl[6]  = mk(0,1,'h100,1,0,0,     0,'hC,  0,0);
    tbl[7]  = mk(0,0,0,    1,1,'h8,   0,'h100,0,0);
    tbl[8]  = mk(0,0,0,    0,0,0,     1,'h100,0,0);
    tbl[9]  = mk(0,0,0,    0,0,0,     1,'h100,0,0);
    tbl[10] = mk(0,0,0,    0,0,0,     1,'h100,0,0);
    tbl[11] = mk(0,0,0,    1,0,0,     1,'h100,0,0);
    tbl[12] = mk(0,0,0,    0,1,'h100, 1,'h104,1,'h100);
    tbl[13] = mk(0,0,0,    1,0,0,     1,'h104,0,0);
    tbl[14] = mk(0,0,0,    1,1,'h104, 1,'h108,1,'h104);
    tbl[15] = mk(0,1,'h200,1,1,'h108, 0,'h10C,0,0);
    tbl[16] = mk(0,0,0,    1,0,0,     1,'h200,0,0);

    do_reset;
    @(negedge clk);
    chk("reset.req", 32'(imem_req_out), 32'h1);
    chk("reset.addr", imem_addr_out, 32'h0);
    chk_out("reset", F, 32'h0, F);

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].st, tbl[i].rd, tbl[i].rpc, tbl[i].rdy, tbl[i].vld, tbl[i].dpc);
      chk($sformatf("vec%0d.req", i), 32'(imem_req_out), 32'(tbl[i].e_req));
      chk($sformatf("vec%0d.addr", i), imem_addr_out, tbl[i].e_addr);
      chk_out($sformatf("vec%0d", i), tbl[i].e_dv, tbl[i].e_pc, F);
    end

    // BTB: train taken, predict, weaken with a same-cycle update, then lose prediction
    do_reset;
    step(F,F,0,F,F,0, T,32'h10,32'h40,T);
    step(F,F,0,F,F,0, T,32'h10,32'h40,T);
    step(F,T,32'h10,F,F,0);
    step(F,F,0,T,F,0);
    chk("btb.req", 32'(imem_req_out), 32'h1);
    chk("btb.addr", imem_addr_out, 32'h10);
    step(F,F,0,F,T,32'h10);
    chk_out("btb.hit", T, 32'h10, T);
    chk("btb.next", imem_addr_out, 32'h40);
    step(F,F,0,F,F,0, T,32'h10,32'h40,F);
    step(F,T,32'h10,F,F,0);
    step(F,F,0,T,F,0, T,32'h10,32'h40,F);
    chk("btb.conc_addr", imem_addr_out, 32'h10);
    step(F,F,0,F,T,32'h10);
    chk_out("btb.old", T, 32'h10, T);
    chk("btb.old_next", imem_addr_out, 32'h40);
    step(F,T,32'h10,F,F,0);
    step(F,F,0,T,F,0);
    step(F,F,0,F,T,32'h10);
    chk_out("btb.weak", T, 32'h10, F);
    chk("btb.weak_next", imem_addr_out, 32'h14);

    // Reset pulled low while waiting on a response
    do_reset;
    step(F,F,0,F,F,0, T,32'h10,32'h40,T);
    step(F,T,32'h10,F,F,0);
    step(F,F,0,T,F,0);
    step(F,F,0,F,F,0);
    chk("rst.wait_addr", imem_addr_out, 32'h40);
    chk("rst.wait_req", 32'(imem_req_out), 32'h0);
    @(posedge clk); #1;
    imem_valid_in = T; imem_data_in = mem_word(32'h10);
    #1 chk_out("rst.pre", T, 32'h10, T);
    #1 reset = 1'b0;
    #1 chk_out("rst.bubble", F, 32'h0, F);
    chk("rst.addr", imem_addr_out, 32'h0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk_out("rst.ignore", F, 32'h0, F);
    chk("rst.req", 32'(imem_req_out), 32'h1);
    chk("rst.req_addr", imem_addr_out, 32'h0);
    step(F,F,0,F,F,0);
    step(F,T,32'h10,F,F,0);
    step(F,F,0,T,F,0);
    step(F,F,0,F,T,32'h10);
    chk_out("rst.btb", T, 32'h10, F);
    chk("rst.btb_next", imem_addr_out, 32'h14);

    // Random traffic against the fetch-stream model
    do_reset;
    for (int k = 0; k < 16; k++) begin mv[k] = F; mpc[k] = '0; mtgt[k] = '0; mctr[k] = 1; end
    exp_pc = 32'h0; q.delete(); held = F; pend = F; cnt = 0; maddr = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      if (pend && cnt == 0) begin
        imem_valid_in = T; imem_data_in = mem_word(maddr); pend = F;
      end else begin
        imem_valid_in = F; imem_data_in = $urandom;
        if (pend) cnt--;
      end
      stall_in             = ($urandom_range(0, 3) == 0);
      redirect_in          = ($urandom_range(0, 15) == 0);
      redirect_pc_in       = 32'($urandom_range(0, 63)) << 2;
      imem_ready_in        = ($urandom_range(0, 2) != 0);
      btb_update_in        = ($urandom_range(0, 3) == 0);
      btb_update_pc_in     = 32'($urandom_range(0, 63)) << 2;
      btb_update_target_in = 32'($urandom_range(0, 63)) << 2;
      btb_update_taken_in  = ($urandom_range(0, 2) != 0);
      @(negedge clk);

      if (redirect_in) begin
        chk("rnd.rd_req", 32'(imem_req_out), 32'h0);
        chk("rnd.rd_instr", instr_out, NOP);
        q.delete(); held = F;
      end else if (held || (imem_valid_in && q.size() > 0)) begin
        it = q[0];
        chk_out("rnd.dlv", T, it.pc, it.pred);
        if (stall_in) begin
          chk("rnd.stall_req", 32'(imem_req_out), 32'h0);
          held = T;
        end else begin
          void'(q.pop_front());
          held = F;
        end
      end else begin
        chk("rnd.bubble", instr_out, NOP);
      end

      if (imem_req_out && imem_ready_in) begin
        chk("rnd.addr", imem_addr_out, exp_pc);
        bi  = exp_pc[5:2];
        hit = mv[bi] && (mpc[bi][31:2] == exp_pc[31:2]);
        pr  = hit && (mctr[bi] >= 2);
        q.push_back('{pc: exp_pc, pred: pr});
        exp_pc = pr ? mtgt[bi] : exp_pc + 32'h4;
        pend = T; maddr = imem_addr_out; cnt = $urandom_range(0, 2);
      end
      if (redirect_in) exp_pc = redirect_pc_in;

      if (btb_update_in) begin
        bi  = btb_update_pc_in[5:2];
        hit = mv[bi] && (mpc[bi][31:2] == btb_update_pc_in[31:2]);
        if (btb_update_taken_in) begin
          mtgt[bi] = btb_update_target_in;
          if (hit) begin
            if (mctr[bi] < 3) mctr[bi]++;
          end else begin
            mv[bi] = T; mpc[bi] = btb_update_pc_in; mctr[bi] = 2;
          end
        end else if (hit && mctr[bi] > 0) begin
          mctr[bi]--;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
